// File: rtl/comparator_3bit_bist.sv
// comparator_3bit_bist: exhaustive 64-pair self-test sweep for a 3-bit magnitude comparator
module comparator_3bit_bist #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [2:0]       in1,
  output logic [2:0]       in2,
  input  logic             out1,
  input  logic             out2,
  input  logic             out3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_a,
  output logic [2:0]       first_fail_b
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FIN} state_t;
  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       in1_q, in1_d, in2_q, in2_d, ffa_q, ffa_d, ffb_q, ffb_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, cap_q, cap_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic             mis;
  assign mis     = {out1, out2, out3} != {in1_q > in2_q, in1_q == in2_q, in1_q < in2_q};
  assign err_inc = (err_q == '1) ? err_q : err_q + 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cap_d   = cap_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        idx_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
        ffa_d   = '0;
        ffb_d   = '0;
        cap_d   = 1'b0;
        busy_d  = 1'b1;
      end
      DRIVE: begin
        in1_d   = idx_q[5:3];
        in2_d   = idx_q[2:0];
        cnt_d   = 4'(SETTLE);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == 4'd1) ? CHECK : WAIT;
      end
      CHECK: begin
        if (mis) begin
          err_d = err_inc;
          cap_d = 1'b1;
          ffa_d = cap_q ? ffa_q : in1_q;
          ffb_d = cap_q ? ffb_q : in2_q;
        end
        // done/busy/pass are registered here so they line up with the FIN cycle
        if (idx_q == 6'd63) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !mis && err_q == '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end
  assign in1          = in1_q;
  assign in2          = in2_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;
endmodule

// File: tb/tb_comparator_3bit_bist.sv
// tb_comparator_3bit_bist: scoreboard bench driving the sweep against good and faulty comparator models
module tb_comparator_3bit_bist;
  logic clk = 0, rst_n = 0, start_m = 0, start_a = 0;
  logic [2:0] in1_m, in2_m, in1_a, in2_a, ffa_m, ffb_m, ffa_a, ffb_a;
  logic o1_m, o2_m, o3_m, o1_a, o2_a, o3_a;
  logic busy_m, done_m, pass_m, busy_a, done_a, pass_a;
  logic [6:0] err_m;
  logic [4:0] err_a;
  int mode_m = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {int err; int pass; int fa; int fb; int cyc;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  // fault modes: 0 good, 1 out2 stuck 0, 2 out1/out3 swapped, 3 all stuck 0
  function automatic logic [2:0] resp(input int mode, input logic [2:0] a, b);
    logic [2:0] g;
    g = {a > b, a == b, a < b};
    return mode == 1 ? {g[2], 1'b0, g[0]} : mode == 2 ? {g[0], g[1], g[2]} : mode == 3 ? 3'b000 : g;
  endfunction
  function automatic exp_t model(input int mode, input int emax, input int cyc);
    exp_t e;
    bit found = 0;
    e = '{0, 0, 0, 0, cyc};
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        if (resp(mode, 3'(a), 3'(b)) != {a > b, a == b, a < b}) begin
          if (!found) begin found = 1; e.fa = a; e.fb = b; end
          if (e.err < emax) e.err++;
        end
    e.pass = (e.err == 0);
    return e;
  endfunction
  assign {o1_m, o2_m, o3_m} = resp(mode_m, in1_m, in2_m);
  assign {o1_a, o2_a, o3_a} = resp(3, in1_a, in2_a);
  comparator_3bit_bist #(.SETTLE(1), .ERR_W(7)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .in1(in1_m), .in2(in2_m),
    .out1(o1_m), .out2(o2_m), .out3(o3_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(err_m), .first_fail_a(ffa_m), .first_fail_b(ffb_m));
  comparator_3bit_bist #(.SETTLE(3), .ERR_W(5)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in1(in1_a), .in2(in2_a),
    .out1(o1_a), .out2(o2_a), .out3(o3_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_a(ffa_a), .first_fail_b(ffb_a));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_m(input string tag);
    chk({tag, "_in"}, {in1_m, in2_m}, 0);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_done"}, done_m, 0);
    chk({tag, "_pass"}, pass_m, 0);
    chk({tag, "_err"}, err_m, 0);
    chk({tag, "_ff"}, {ffa_m, ffb_m}, 0);
  endtask
  task automatic run_main(input int mode, input int restart_at, input int abort_at);
    exp_t e;
    int n = 0, bad = 0, dones = 0;
    mode_m = mode;
    if (abort_at == 0) sb.push_back(model(mode, 127, 192));
    @(negedge clk) start_m = 1;
    @(posedge clk) #1 start_m = 0;
    chk("busy_rise", busy_m, 1);
    while (n < 1000) begin
      @(posedge clk) #1 n++;
      start_m = (n == restart_at);
      if (n == abort_at) begin
        #2 rst_n = 0;
        #1 chk_reset_m("abort");
        repeat (4) begin @(posedge clk) #1 dones += done_m; end
        chk("abort_no_done", dones, 0);
        @(negedge clk) rst_n = 1;
        return;
      end
      if (done_m) break;
      if (!busy_m) bad++;
    end
    chk("busy_hold", bad, 0);
    if (sb.size() == 0) begin chk("sb_empty", 1, 0); return; end
    e = sb.pop_front();
    chk("done_cycle", n, e.cyc);
    chk("busy_fall", busy_m, 0);
    chk("err_count", err_m, e.err);
    chk("pass", pass_m, e.pass);
    chk("first_fail", {ffa_m, ffb_m}, {e.fa[2:0], e.fb[2:0]});
    chk("last_vec", {in1_m, in2_m}, 6'o77);
    @(posedge clk) #1 chk("done_pulse", done_m, 0);
    chk("pass_hold", pass_m, e.pass);
  endtask
  initial begin
    exp_t e;
    int n = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_m("reset");
    @(negedge clk) rst_n = 1;
    run_main(0, 0, 0);
    run_main(1, 0, 0);
    run_main(2, 0, 0);
    run_main(0, 50, 0);
    run_main(0, 0, 61);
    run_main(0, 0, 0);
    sb.push_back(model(3, 31, 320));
    @(negedge clk) start_a = 1;
    @(posedge clk) #1 start_a = 0;
    while (n < 2000 && !done_a) begin @(posedge clk) #1 n++; end
    e = sb.pop_front();
    chk("alt_done_cycle", n, e.cyc);
    chk("alt_err_sat", err_a, e.err);
    chk("alt_pass", pass_a, e.pass);
    chk("alt_first_fail", {ffa_a, ffb_a}, {e.fa[2:0], e.fb[2:0]});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
